// File: rtl/error_checking_pkg.sv
// Shared definitions for the OBC error-checking pipeline.
// Contents:
//   Q_WIDTH           question/answer width
//   state_e           challenge sequencer states (IDLE/ISSUE/FORWARD/NEXT)
//   LFSR_TAP_HI/LO    feedback taps of the x^4+x^3+1 question generator
//   expected_answer() reference OBC response, shared with the checker side
package error_checking_pkg;

  localparam int unsigned Q_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    FORWARD = 2'd2,
    NEXT    = 2'd3
  } state_e;

  localparam int unsigned LFSR_TAP_HI = 3;
  localparam int unsigned LFSR_TAP_LO = 2;

  function automatic logic [Q_WIDTH-1:0] expected_answer(input logic [Q_WIDTH-1:0] q);
    return {q[3] ^ q[2], q[2] ^ q[1], q[1] ^ q[0], ~q[0]};
  endfunction

endpackage

// File: rtl/question_lfsr.sv
// 4-bit Fibonacci LFSR (x^4+x^3+1) producing the question sequence.
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-high reset, reloads the seed
//   advance  in   step the sequence by one on the next rising edge
//   q        out  current LFSR value (never zero)
module question_lfsr
  import error_checking_pkg::*;
#(
  parameter logic [Q_WIDTH-1:0] SEED = 4'b1001
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               advance,
  output logic [Q_WIDTH-1:0] q
);

  // An all-zero seed would lock the register up, so substitute 0001.
  localparam logic [Q_WIDTH-1:0] SEED_EFF = (SEED == '0) ? 4'b0001 : SEED;

  logic [Q_WIDTH-1:0] r_lfsr;
  logic               w_feedback;

  assign w_feedback = r_lfsr[LFSR_TAP_HI] ^ r_lfsr[LFSR_TAP_LO];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= SEED_EFF;
    end else if (advance) begin
      r_lfsr <= {r_lfsr[Q_WIDTH-2:0], w_feedback};
    end
  end

  assign q = r_lfsr;

endmodule

// File: rtl/challenge_sequencer.sv
// Challenge sequencer: issues LFSR questions to the OBC, waits (with timeout)
// for the answer and forwards each (question, answer, timeout) triple to the
// checker over a valid/ready handshake, for ROUNDS rounds per run.
// Ports:
//   clk, reset                      clock / asynchronous active-high reset
//   start                           begin a run (only honoured in IDLE)
//   question, q_valid               question presented to the OBC
//   answer_obc, ans_valid           OBC answer strobe (only honoured in ISSUE)
//   chk_valid, chk_ready            handshake towards the checker
//   chk_question/answer/timeout     forwarded triple, held until accepted
//   busy, done, round_idx           status: not idle, end-of-run pulse, round
module challenge_sequencer
  import error_checking_pkg::*;
#(
  parameter logic [Q_WIDTH-1:0] SEED           = 4'b1001,
  parameter int unsigned        TIMEOUT_CYCLES = 16,
  parameter int unsigned        ROUNDS         = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [Q_WIDTH-1:0] question,
  output logic               q_valid,
  input  logic [Q_WIDTH-1:0] answer_obc,
  input  logic               ans_valid,
  output logic               chk_valid,
  input  logic               chk_ready,
  output logic [Q_WIDTH-1:0] chk_question,
  output logic [Q_WIDTH-1:0] chk_answer,
  output logic               chk_timeout,
  output logic               busy,
  output logic               done,
  output logic [3:0]         round_idx
);

  localparam logic [7:0] LAST_TICK  = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  state_e             r_state;
  logic [7:0]         r_timer;
  logic [3:0]         r_round;
  logic               r_q_valid;
  logic               r_chk_valid;
  logic               r_busy;
  logic               r_done;
  logic               r_chk_timeout;
  logic [Q_WIDTH-1:0] r_chk_question;
  logic [Q_WIDTH-1:0] r_chk_answer;

  logic               w_advance;
  logic [Q_WIDTH-1:0] w_lfsr_q;

  // The sequence only moves once a round has been accepted.
  assign w_advance = (r_state == NEXT);

  question_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (w_advance),
    .q       (w_lfsr_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_timer        <= '0;
      r_round        <= '0;
      r_q_valid      <= 1'b0;
      r_chk_valid    <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_chk_timeout  <= 1'b0;
      r_chk_question <= '0;
      r_chk_answer   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state   <= ISSUE;
            r_round   <= '0;
            r_timer   <= '0;
            r_q_valid <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        ISSUE: begin
          r_timer <= r_timer + 8'd1;
          // An answer on the timeout cycle still counts as an answer.
          if (ans_valid) begin
            r_chk_question <= w_lfsr_q;
            r_chk_answer   <= answer_obc;
            r_chk_timeout  <= 1'b0;
            r_q_valid      <= 1'b0;
            r_chk_valid    <= 1'b1;
            r_state        <= FORWARD;
          end else if (r_timer == LAST_TICK) begin
            r_chk_question <= w_lfsr_q;
            r_chk_answer   <= '0;
            r_chk_timeout  <= 1'b1;
            r_q_valid      <= 1'b0;
            r_chk_valid    <= 1'b1;
            r_state        <= FORWARD;
          end
        end
        FORWARD: begin
          if (chk_ready) begin
            r_chk_valid <= 1'b0;
            r_state     <= NEXT;
            // done is visible during the final NEXT cycle.
            if (r_round == LAST_ROUND) begin
              r_done <= 1'b1;
            end
          end
        end
        NEXT: begin
          r_timer <= '0;
          if (r_round == LAST_ROUND) begin
            r_round <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_round   <= r_round + 4'd1;
            r_q_valid <= 1'b1;
            r_state   <= ISSUE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign question     = w_lfsr_q;
  assign q_valid      = r_q_valid;
  assign chk_valid    = r_chk_valid;
  assign chk_question = r_chk_question;
  assign chk_answer   = r_chk_answer;
  assign chk_timeout  = r_chk_timeout;
  assign busy         = r_busy;
  assign done         = r_done;
  assign round_idx    = r_round;

endmodule

// File: tb/tb_challenge_sequencer.sv
// Self-checking bench for challenge_sequencer: randomized OBC/checker behaviour
// compared against a rule-level model of the question sequence and timing.
module tb_challenge_sequencer;

  localparam logic [3:0] SEED    = 4'b1001;
  localparam int         TIMEOUT = 16;
  localparam int         ROUNDS  = 10;

  logic       clk = 1'b0;
  logic       reset, start, ans_valid, chk_ready;
  logic [3:0] answer_obc;
  logic [3:0] question, chk_question, chk_answer, round_idx;
  logic       q_valid, chk_valid, chk_timeout, busy, done;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] m_lfsr;

  challenge_sequencer #(
    .SEED           (SEED),
    .TIMEOUT_CYCLES (TIMEOUT),
    .ROUNDS         (ROUNDS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .question     (question),
    .q_valid      (q_valid),
    .answer_obc   (answer_obc),
    .ans_valid    (ans_valid),
    .chk_valid    (chk_valid),
    .chk_ready    (chk_ready),
    .chk_question (chk_question),
    .chk_answer   (chk_answer),
    .chk_timeout  (chk_timeout),
    .busy         (busy),
    .done         (done),
    .round_idx    (round_idx)
  );

  always #5 clk = ~clk;

  // Next question from the x^4+x^3+1 rule using plain arithmetic.
  function automatic logic [3:0] model_next(input logic [3:0] q);
    int v;
    v = int'(q);
    return 4'(((v * 2) % 16) + (((v / 8) + (v / 4)) % 2));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; ans_valid = 1'b0; chk_ready = 1'b0; answer_obc = '0;
    repeat (2) step();
    reset = 1'b0;
    m_lfsr = SEED;
    step();
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Drives one round from the first ISSUE cycle to the cycle after acceptance.
  // ans_delay = ISSUE cycle index (0-based) on which ans_valid is raised.
  task automatic do_round(input int ans_delay, input logic [3:0] ans, input int stall,
                          input bit poke, output logic [3:0] o_q, output logic o_qv,
                          output logic [3:0] o_round, output int o_lat,
                          output logic [3:0] o_cq, output logic [3:0] o_ans,
                          output logic o_to, output bit o_stable, output logic o_done);
    o_q = question; o_qv = q_valid; o_round = round_idx; o_lat = -1; chk_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      ans_valid  = (i == ans_delay);
      answer_obc = (i == ans_delay) ? ans : 4'($urandom);
      start      = poke ? 1'($urandom) : 1'b0;
      step();
      if (chk_valid) begin
        o_lat = i + 1;
        break;
      end
    end
    ans_valid = 1'b0; start = 1'b0;
    o_cq = chk_question; o_ans = chk_answer; o_to = chk_timeout; o_stable = 1'b1;
    for (int k = 0; k < stall; k++) begin
      ans_valid  = 1'($urandom);
      answer_obc = 4'($urandom);
      start      = poke ? 1'($urandom) : 1'b0;
      step();
      if ({chk_valid, q_valid, chk_question, chk_answer, chk_timeout, question} !==
          {1'b1, 1'b0, o_cq, o_ans, o_to, o_q}) o_stable = 1'b0;
    end
    ans_valid = 1'b0; chk_ready = 1'b1;
    start = poke ? 1'($urandom) : 1'b0;
    step();
    o_done = done;
    chk_ready = 1'b0; start = 1'b0;
    step();
  endtask

  // A full run of ROUNDS rounds with every round checked against the model.
  task automatic run_rounds(input bit poke, input int fixed_delay, output int n_done);
    logic [3:0] oq, oround, ocq, oans;
    logic       oqv, oto, odone, exp_to;
    logic [3:0] exp_ans, ans;
    bit         ostable;
    int         olat, delay, exp_lat;
    n_done = 0;
    for (int r = 0; r < ROUNDS; r++) begin
      delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 17));
      ans   = 4'($urandom);
      do_round(delay, ans, int'($urandom_range(0, 3)), poke,
               oq, oqv, oround, olat, ocq, oans, oto, ostable, odone);
      exp_lat = (delay < TIMEOUT) ? delay + 1 : TIMEOUT;
      exp_ans = (delay < TIMEOUT) ? ans : 4'b0000;
      exp_to  = (delay < TIMEOUT) ? 1'b0 : 1'b1;
      n_checks++;
      if (oqv !== 1'b1) begin
        n_errors++; $display("FAIL q_valid r%0d got %b want 1", r, oqv);
      end
      n_checks++;
      if (oround !== 4'(r)) begin
        n_errors++; $display("FAIL round_idx r%0d got %0d want %0d", r, oround, r);
      end
      n_checks++;
      if (oq !== m_lfsr) begin
        n_errors++; $display("FAIL question r%0d got %b want %b", r, oq, m_lfsr);
      end
      n_checks++;
      if (olat !== exp_lat) begin
        n_errors++; $display("FAIL latency r%0d got %0d want %0d", r, olat, exp_lat);
      end
      n_checks++;
      if ({ocq, oans, oto} !== {m_lfsr, exp_ans, exp_to}) begin
        n_errors++;
        $display("FAIL triple r%0d got q=%b a=%b t=%b want q=%b a=%b t=%b",
                 r, ocq, oans, oto, m_lfsr, exp_ans, exp_to);
      end
      n_checks++;
      if (ostable !== 1'b1) begin
        n_errors++; $display("FAIL stall_stable r%0d got %b want 1", r, ostable);
      end
      n_checks++;
      if (odone !== (r == ROUNDS - 1)) begin
        n_errors++; $display("FAIL done r%0d got %b want %b", r, odone, (r == ROUNDS - 1));
      end
      if (odone === 1'b1) n_done++;
      m_lfsr = model_next(m_lfsr);
    end
    n_checks++;
    if ({busy, done, q_valid, chk_valid, question} !== {4'b0000, m_lfsr}) begin
      n_errors++;
      $display("FAIL end_of_run got busy=%b done=%b qv=%b cv=%b q=%b want 0 0 0 0 %b",
               busy, done, q_valid, chk_valid, question, m_lfsr);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (question !== SEED) begin
      n_errors++; $display("FAIL reset_question got %b want %b", question, SEED);
    end
    n_checks++;
    if ({q_valid, chk_valid, chk_question, chk_answer, chk_timeout, busy, done, round_idx}
        !== 19'd0) begin
      n_errors++;
      $display("FAIL reset_outputs got qv=%b cv=%b cq=%b ca=%b ct=%b b=%b d=%b r=%0d want 0",
               q_valid, chk_valid, chk_question, chk_answer, chk_timeout, busy, done,
               round_idx);
    end
  endtask

  task automatic test_full_run();
    int nd;
    do_reset();
    start_run();
    run_rounds(1'b0, 2, nd);
    n_checks++;
    if (nd !== 1) begin
      n_errors++; $display("FAIL full_run_done_count got %0d want 1", nd);
    end
  endtask

  task automatic test_timeout();
    logic [3:0] oq, oround, ocq, oans;
    logic       oqv, oto, odone;
    bit         ostable;
    int         olat;
    do_reset();
    start_run();
    do_round(1000, 4'b0000, 0, 1'b0, oq, oqv, oround, olat, ocq, oans, oto, ostable, odone);
    n_checks++;
    if (olat !== TIMEOUT) begin
      n_errors++; $display("FAIL timeout_latency got %0d want %0d", olat, TIMEOUT);
    end
    n_checks++;
    if ({ocq, oans, oto} !== {SEED, 4'b0000, 1'b1}) begin
      n_errors++;
      $display("FAIL timeout_triple got q=%b a=%b t=%b want q=%b a=0000 t=1",
               ocq, oans, oto, SEED);
    end
    m_lfsr = model_next(m_lfsr);
    n_checks++;
    if ({q_valid, question, round_idx} !== {1'b1, m_lfsr, 4'd1}) begin
      n_errors++;
      $display("FAIL timeout_next got qv=%b q=%b r=%0d want 1 %b 1",
               q_valid, question, round_idx, m_lfsr);
    end
  endtask

  task automatic test_answer_on_timeout();
    logic [3:0] oq, oround, ocq, oans, a;
    logic       oqv, oto, odone;
    bit         ostable;
    int         olat;
    do_reset();
    start_run();
    do_round(TIMEOUT - 1, 4'b0110, 0, 1'b0, oq, oqv, oround, olat, ocq, oans, oto, ostable,
             odone);
    n_checks++;
    if ({olat == TIMEOUT, oans, oto} !== {1'b1, 4'b0110, 1'b0}) begin
      n_errors++;
      $display("FAIL answer_on_timeout got lat=%0d a=%b t=%b want lat=%0d a=0110 t=0",
               olat, oans, oto, TIMEOUT);
    end
    a = 4'($urandom);
    do_round(TIMEOUT - 2, a, 0, 1'b0, oq, oqv, oround, olat, ocq, oans, oto, ostable, odone);
    n_checks++;
    if ({olat == TIMEOUT - 1, oans, oto} !== {1'b1, a, 1'b0}) begin
      n_errors++;
      $display("FAIL answer_before_timeout got lat=%0d a=%b t=%b want lat=%0d a=%b t=0",
               olat, oans, oto, TIMEOUT - 1, a);
    end
    do_round(TIMEOUT, a, 0, 1'b0, oq, oqv, oround, olat, ocq, oans, oto, ostable, odone);
    n_checks++;
    if ({olat == TIMEOUT, oans, oto} !== {1'b1, 4'b0000, 1'b1}) begin
      n_errors++;
      $display("FAIL answer_after_timeout got lat=%0d a=%b t=%b want lat=%0d a=0000 t=1",
               olat, oans, oto, TIMEOUT);
    end
  endtask

  task automatic test_stall();
    logic [3:0] oq, oround, ocq, oans, a;
    logic       oqv, oto, odone;
    bit         ostable;
    int         olat, d;
    do_reset();
    start_run();
    d = int'($urandom_range(0, TIMEOUT - 1));
    a = 4'($urandom);
    do_round(d, a, 20, 1'b0, oq, oqv, oround, olat, ocq, oans, oto, ostable, odone);
    n_checks++;
    if (ostable !== 1'b1) begin
      n_errors++; $display("FAIL stall20_stable got %b want 1", ostable);
    end
    n_checks++;
    if ({ocq, oans, oto} !== {SEED, a, 1'b0}) begin
      n_errors++;
      $display("FAIL stall20_triple got q=%b a=%b t=%b want q=%b a=%b t=0",
               ocq, oans, oto, SEED, a);
    end
    m_lfsr = model_next(m_lfsr);
    n_checks++;
    if ({q_valid, question} !== {1'b1, m_lfsr}) begin
      n_errors++;
      $display("FAIL stall20_next got qv=%b q=%b want 1 %b", q_valid, question, m_lfsr);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] oq, oround, ocq, oans;
    logic       oqv, oto, odone;
    bit         ostable;
    int         olat;
    do_reset();
    start_run();
    for (int r = 0; r < 3; r++) begin
      do_round(int'($urandom_range(0, 5)), 4'($urandom), 0, 1'b0,
               oq, oqv, oround, olat, ocq, oans, oto, ostable, odone);
      m_lfsr = model_next(m_lfsr);
    end
    n_checks++;
    if ({q_valid, round_idx, question} !== {1'b1, 4'd3, m_lfsr}) begin
      n_errors++;
      $display("FAIL mid_round4 got qv=%b r=%0d q=%b want 1 3 %b",
               q_valid, round_idx, question, m_lfsr);
    end
    repeat (3) step();
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({q_valid, chk_valid, chk_question, chk_answer, chk_timeout, busy, done, round_idx,
         question} !== {19'd0, SEED}) begin
      n_errors++;
      $display("FAIL async_reset got qv=%b cv=%b b=%b d=%b r=%0d q=%b want 0s q=%b",
               q_valid, chk_valid, busy, done, round_idx, question, SEED);
    end
    step();
    reset = 1'b0;
    m_lfsr = SEED;
    repeat (3) step();
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_errors++; $display("FAIL post_reset_idle got busy=%b done=%b want 0 0", busy, done);
    end
    start_run();
    n_checks++;
    if ({q_valid, question, round_idx} !== {1'b1, SEED, 4'd0}) begin
      n_errors++;
      $display("FAIL restart got qv=%b q=%b r=%0d want 1 %b 0",
               q_valid, question, round_idx, SEED);
    end
  endtask

  task automatic test_start_ignored();
    int nd;
    do_reset();
    start_run();
    run_rounds(1'b1, -1, nd);
    n_checks++;
    if (nd !== 1) begin
      n_errors++; $display("FAIL run1_done_count got %0d want 1", nd);
    end
    repeat (5) step();
    n_checks++;
    if ({busy, q_valid} !== 2'b00) begin
      n_errors++; $display("FAIL no_extra_run got busy=%b qv=%b want 0 0", busy, q_valid);
    end
    start_run();
    run_rounds(1'b1, -1, nd);
    n_checks++;
    if (nd !== 1) begin
      n_errors++; $display("FAIL run2_done_count got %0d want 1", nd);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; ans_valid = 1'b0; chk_ready = 1'b0; answer_obc = '0;
    m_lfsr = SEED;
    test_reset();
    test_full_run();
    test_timeout();
    test_answer_on_timeout();
    test_stall();
    test_reset_mid();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
